// File: rtl/mk_pipeline_fifo_ehr.sv
// Three-port ephemeral history register. Each write port is seen by the
// read port of the next higher index within the same cycle.
module mkEHR #(
  parameter int              size = 1,
  parameter logic [size-1:0] init = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [size-1:0] write_0,
  input  logic            EN_write_0,
  input  logic [size-1:0] write_1,
  input  logic            EN_write_1,
  input  logic [size-1:0] write_2,
  input  logic            EN_write_2,
  output logic [size-1:0] read_0,
  output logic [size-1:0] read_1
);

  logic [size-1:0] value;
  logic [size-1:0] after_1;
  logic [size-1:0] after_2;

  // Ports are chained in index order: a later port sees earlier writes.
  always_comb begin
    read_0  = value;
    read_1  = EN_write_0 ? write_0 : value;
    after_1 = EN_write_1 ? write_1 : read_1;
    after_2 = EN_write_2 ? write_2 : after_1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      value <= init;
    end else begin
      value <= after_2;
    end
  end

endmodule

// File: rtl/mk_pipeline_fifo.sv
// Pipeline FIFO: dequeue is ordered before enqueue, so a full FIFO still
// accepts a word in any cycle that also dequeues; clear is ordered last.
module mk_pipeline_fifo #(
  parameter int size     = 1,
  parameter int depth    = 2,
  parameter int logDepth = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [size-1:0]     enq_x,
  input  logic                EN_enq,
  output logic                RDY_enq,
  output logic [size-1:0]     first,
  output logic                RDY_first,
  input  logic                EN_deq,
  output logic                RDY_deq,
  input  logic                EN_clear,
  output logic                RDY_clear,
  output logic [logDepth:0]   count
);

  localparam logic [logDepth:0]   fullCount = (logDepth + 1)'(depth);
  localparam logic [logDepth:0]   countOne  = (logDepth + 1)'(1);
  localparam logic [logDepth-1:0] ptrOne    = logDepth'(1);

  logic [size-1:0]     buffer [depth];
  logic [logDepth-1:0] head;
  logic [logDepth-1:0] tail;

  logic [logDepth:0] count_now;
  logic [logDepth:0] count_after_deq;
  logic              not_empty;
  logic              deq_fire;
  logic              enq_fire;

  assign not_empty = (count_now != '0);
  assign deq_fire  = EN_deq && not_empty;
  assign enq_fire  = EN_enq && RDY_enq;

  // EN_deq feeds RDY_enq combinationally so a full FIFO can stream.
  always_comb begin
    RDY_enq   = (count_now != fullCount) || EN_deq;
    RDY_deq   = not_empty;
    RDY_first = not_empty;
    RDY_clear = 1'b1;
    count     = count_now;
    first     = not_empty ? buffer[head] : '0;
  end

  mkEHR #(
    .size (logDepth + 1),
    .init ('0)
  ) occupancy (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .write_0    (count_now - countOne),
    .EN_write_0 (deq_fire),
    .write_1    (count_after_deq + countOne),
    .EN_write_1 (enq_fire),
    .write_2    ('0),
    .EN_write_2 (EN_clear),
    .read_0     (count_now),
    .read_1     (count_after_deq)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      head <= '0;
      tail <= '0;
    end else if (EN_clear) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (deq_fire) begin
        head <= head + ptrOne;
      end
      if (enq_fire) begin
        tail <= tail + ptrOne;
      end
    end
  end

  // Storage is deliberately left out of reset and clear.
  always_ff @(posedge CLK) begin
    if (RST_N && !EN_clear && enq_fire) begin
      buffer[tail] <= enq_x;
    end
  end

endmodule

// File: tb/tb_mk_pipeline_fifo.sv
// Directed self-checking bench for mk_pipeline_fifo at size=8, depth=4.
module tb_mk_pipeline_fifo;

  logic       CLK;
  logic       RST_N;
  logic [7:0] enq_x;
  logic       EN_enq;
  logic       RDY_enq;
  logic [7:0] first;
  logic       RDY_first;
  logic       EN_deq;
  logic       RDY_deq;
  logic       EN_clear;
  logic       RDY_clear;
  logic [2:0] count;

  int testCount;
  int failCount;

  mk_pipeline_fifo #(
    .size     (8),
    .depth    (4),
    .logDepth (2)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .enq_x     (enq_x),
    .EN_enq    (EN_enq),
    .RDY_enq   (RDY_enq),
    .first     (first),
    .RDY_first (RDY_first),
    .EN_deq    (EN_deq),
    .RDY_deq   (RDY_deq),
    .EN_clear  (EN_clear),
    .RDY_clear (RDY_clear),
    .count     (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic enq, input logic [7:0] data,
                               input logic deq, input logic clr);
    EN_enq   = enq;
    enq_x    = data;
    EN_deq   = deq;
    EN_clear = clr;
  endtask

  // Advance past the next rising edge, then return inputs to idle.
  task automatic tick();
    @(posedge CLK);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " RDY_enq"},   32'(RDY_enq),   32'd1);
    checkOutput({tag, " RDY_deq"},   32'(RDY_deq),   32'd0);
    checkOutput({tag, " RDY_first"}, 32'(RDY_first), 32'd0);
    checkOutput({tag, " RDY_clear"}, 32'(RDY_clear), 32'd1);
    checkOutput({tag, " count"},     32'(count),     32'd0);
    checkOutput({tag, " first"},     32'(first),     32'd0);
  endtask

  initial begin
    logic [7:0] drain [4];
    testCount = 0;
    failCount = 0;
    drain[0] = 8'h22;
    drain[1] = 8'h33;
    drain[2] = 8'h44;
    drain[3] = 8'h55;
    RST_N = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    checkIdleOutputs("reset");

    // Fill to capacity; first word visible one cycle after its enqueue.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    checkOutput("latency first", 32'(first), 32'h11);
    checkOutput("latency count", 32'(count), 32'd1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    tick();
    checkOutput("full count",   32'(count),   32'd4);
    checkOutput("full RDY_enq", 32'(RDY_enq), 32'd0);
    checkOutput("full first",   32'(first),   32'h11);

    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    checkOutput("ignored enq count", 32'(count), 32'd4);
    checkOutput("ignored enq first", 32'(first), 32'h11);

    // Enqueue and dequeue together while full.
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    #1;
    checkOutput("full deq RDY_enq", 32'(RDY_enq), 32'd1);
    tick();
    checkOutput("full swap count", 32'(count), 32'd4);
    checkOutput("full swap first", 32'(first), 32'h22);

    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain %0d", i), 32'(first), 32'(drain[i]));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
    end
    checkIdleOutputs("drained");

    // Stream at occupancy 2 across pointer wrap.
    applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("stream first %0d", i), 32'(first), 32'(8'hA0 + i));
      applyStimulus(1'b1, 8'(8'hA2 + i), 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("stream count %0d", i), 32'(count), 32'd2);
    end
    checkOutput("stream tail first", 32'(first), 32'hAA);

    // Clear at occupancy 3 overrides simultaneous enq and deq.
    applyStimulus(1'b1, 8'hAC, 1'b0, 1'b0);
    tick();
    checkOutput("pre-clear count", 32'(count), 32'd3);
    applyStimulus(1'b1, 8'hAD, 1'b1, 1'b1);
    tick();
    checkIdleOutputs("clear");

    // Dequeue request while empty is ignored; enqueue still lands.
    applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
    tick();
    checkOutput("empty deq count", 32'(count), 32'd1);
    checkOutput("empty deq first", 32'(first), 32'h66);
    applyStimulus(1'b1, 8'h67, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h68, 1'b0, 1'b0);
    tick();
    checkOutput("pre-reset count", 32'(count), 32'd3);

    // Reset wins over a simultaneous enqueue.
    RST_N = 1'b0;
    applyStimulus(1'b1, 8'h69, 1'b1, 1'b0);
    tick();
    RST_N = 1'b1;
    checkIdleOutputs("mid reset");
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    checkOutput("post-reset first", 32'(first), 32'h77);
    checkOutput("post-reset count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
